// File: rtl/fourbyone_rr_select_if.sv
// Request/grant bundle between the round-robin select and its users.
// The arbiter sits on the slave side; requesters and the bench sit on the master side.
interface fourbyone_rr_select_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] S;
  logic [3:0] grant;
  logic       valid;
  logic       expired;

  modport master (output req, done, input S, grant, valid, expired);
  modport slave  (input req, done, output S, grant, valid, expired);
endinterface

// File: rtl/fourbyone_rr_select.sv
// Four-channel round-robin arbiter producing the registered mux select S.
// Define RR_TIMEOUT_EN to compile in the MAX_HOLD forced-release timer.
//
// state | meaning
// IDLE  | no grant active; scan req starting after the last-granted channel
// GRANT | channel S owns the mux until done, req[S] drop, or timeout
module fourbyone_rr_select #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic                   clk,
  input logic                   rst,
  fourbyone_rr_select_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [1:0] last_q, last_d;
  logic [3:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic       expired_q, expired_d;

  logic [1:0] pick;
  logic [1:0] cand;
  logic       pick_ok;
  logic       release_normal;
  logic       timeout;

`ifdef RR_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == 8'(MAX_HOLD - 1));
`else
  logic unused_max_hold;
  assign unused_max_hold = ^8'(MAX_HOLD);
  assign timeout         = 1'b0;
`endif

  assign release_normal = bus.done || !bus.req[s_q];

  // Rotating scan: last+1 first, last itself has lowest priority.
  always_comb begin
    pick    = last_q;
    cand    = last_q;
    pick_ok = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_ok && bus.req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    last_d    = last_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    expired_d = 1'b0;
`ifdef RR_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = GRANT;
          s_d     = pick;
          last_d  = pick;
          grant_d = 4'b0001 << pick;
          valid_d = 1'b1;
`ifdef RR_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (release_normal || timeout) begin
          // S is left alone so the downstream mux select does not toggle.
          state_d   = IDLE;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          expired_d = timeout && !release_normal;
        end
`ifdef RR_TIMEOUT_EN
        else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= 2'b00;
      last_q    <= 2'b11;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
`ifdef RR_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
`ifdef RR_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.S       = s_q;
  assign bus.grant   = grant_q;
  assign bus.valid   = valid_q;
  assign bus.expired = expired_q;

endmodule
